control_unit: RTL and testbench

Hardwired Moore control sequencer for the Datapath2 single-bus RISC datapath. It drives every datapath control strobe: register-file select (Gra/Grb/Grc, Rin/Rout, BAout), bus drivers, register loads, memory Read/Write, and the ALU OpCode. It runs the fetch, decode and execute sequences for the phase-2 instruction subset. It sits beside Datapath2 in the top-level CPU, takes IR[31:27] and CON_FF back from the datapath, and adds a memory-ready wait and a run/stop handshake.

---
 rtl/control_unit.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Moore control sequencer for the Datapath2 single-bus RISC datapath: fetch, decode, execute strobes.
// Latency: strobes decode from the registered state; ld/st 9, branch 8, ldi/addi/ALU 7, out 5, nop 4 cycles.
// Backpressure: mem_ready low holds F2 / ld-E4 / st-E5; Stop parks the sequencer in PAUSE at the next boundary.
module control_unit #(
   parameter int              OP_W       = 5,
   parameter logic [OP_W-1:0] ALU_ADD_OP = 5'd2,
   parameter logic [OP_W-1:0] ALU_INC_OP = 5'd12
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [OP_W-1:0] IR_op,
   input  logic            CON_FF,
   input  logic            mem_ready,
   input  logic            Stop,
   output logic            PCout,
   output logic            Zlowout,
   output logic            MDRout,
   output logic            Cout,
   output logic            BAout,
   output logic            MARin,
   output logic            Zin,
   output logic            PCin,
   output logic            MDRin,
   output logic            IRin,
   output logic            Yin,
   output logic            CONin,
   output logic            OutportIn,
   output logic            Gra,
   output logic            Grb,
   output logic            Grc,
   output logic            Rin,
   output logic            Rout,
   output logic            Read,
   output logic            Write,
   output logic [OP_W-1:0] OpCode,
   output logic            Run,
   output logic            Illegal
);

   typedef enum logic [3:0] {
      S_RST   = 4'd0,
      S_PAUSE = 4'd1,
      S_HALT  = 4'd2,
      S_F0    = 4'd3,
      S_F1    = 4'd4,
      S_F2    = 4'd5,
      S_F3    = 4'd6,
      S_E1    = 4'd7,
      S_E2    = 4'd8,
      S_E3    = 4'd9,
      S_E4    = 4'd10,
      S_E5    = 4'd11
   } state_t;

   // Instruction classes; every opcode that is not listed decodes to C_ILL.
   typedef enum logic [3:0] {
      C_LD, C_LDI, C_ST, C_ALU, C_ADDI, C_BR, C_OUT, C_NOP, C_HALT, C_ILL
   } op_cls_t;

   // All datapath strobes carried as one bundle.
   typedef struct packed {
      logic pc_out;
      logic zlow_out;
      logic mdr_out;
      logic c_out;
      logic ba_out;
      logic mar_in;
      logic z_in;
      logic pc_in;
      logic mdr_in;
      logic ir_in;
      logic y_in;
      logic con_in;
      logic outport_in;
      logic gra;
      logic grb;
      logic grc;
      logic r_in;
      logic r_out;
      logic rd;
      logic wr;
   } ctl_t;

   localparam logic [OP_W-1:0] OPC_LD     = OP_W'(0);
   localparam logic [OP_W-1:0] OPC_LDI    = OP_W'(1);
   localparam logic [OP_W-1:0] OPC_ST     = OP_W'(2);
   localparam logic [OP_W-1:0] OPC_ALU_LO = OP_W'(3);
   localparam logic [OP_W-1:0] OPC_ALU_HI = OP_W'(11);
   localparam logic [OP_W-1:0] OPC_ADDI   = OP_W'(13);
   localparam logic [OP_W-1:0] OPC_BR     = OP_W'(18);
   localparam logic [OP_W-1:0] OPC_OUT    = OP_W'(22);
   localparam logic [OP_W-1:0] OPC_NOP    = OP_W'(26);
   localparam logic [OP_W-1:0] OPC_HALT   = OP_W'(27);

   state_t  state_q, state_d;
   op_cls_t op_cls;
   logic [2:0] op_len;     // number of E-states the instruction uses
   state_t  bnd_state;     // destination when leaving an instruction boundary
   ctl_t    ctl;
   logic    illegal_q;

   // Classify the opcode presented by the IR.
   always_comb begin
      op_cls = C_ILL;
      if (IR_op == OPC_LD)                                   op_cls = C_LD;
      else if (IR_op == OPC_LDI)                             op_cls = C_LDI;
      else if (IR_op == OPC_ST)                              op_cls = C_ST;
      else if (IR_op >= OPC_ALU_LO && IR_op <= OPC_ALU_HI)   op_cls = C_ALU;
      else if (IR_op == OPC_ADDI)                            op_cls = C_ADDI;
      else if (IR_op == OPC_BR)                              op_cls = C_BR;
      else if (IR_op == OPC_OUT)                             op_cls = C_OUT;
      else if (IR_op == OPC_NOP)                             op_cls = C_NOP;
      else if (IR_op == OPC_HALT)                            op_cls = C_HALT;
   end

   // Execute length per class; the last listed E-state hands control to the boundary.
   always_comb begin
      op_len = 3'd0;
      case (op_cls)
         C_LD, C_ST:           op_len = 3'd5;
         C_LDI, C_ALU, C_ADDI: op_len = 3'd3;
         C_BR:                 op_len = 3'd4;
         C_OUT:                op_len = 3'd1;
         default:              op_len = 3'd0;
      endcase
   end

   assign bnd_state = Stop ? S_PAUSE : S_F0;

   // State register; clr aborts any instruction in flight.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) state_q <= S_RST;
      else     state_q <= state_d;
   end

   // Sticky flag for an undefined opcode reaching decode.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)                                     illegal_q <= 1'b0;
      else if (state_q == S_F3 && op_cls == C_ILL) illegal_q <= 1'b1;
   end

   // Next-state: fetch, decode dispatch, execute walk and memory waits.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST:   state_d = bnd_state;
         S_PAUSE: if (!Stop) state_d = S_F0;
         S_HALT:  state_d = S_HALT;
         S_F0:    state_d = S_F1;
         S_F1:    state_d = S_F2;
         S_F2:    if (mem_ready) state_d = S_F3;
         S_F3: begin
            if (op_cls == C_HALT || op_cls == C_ILL) state_d = S_HALT;
            else if (op_len == 3'd0)                 state_d = bnd_state;
            else                                     state_d = S_E1;
         end
         S_E1:    state_d = (op_len == 3'd1) ? bnd_state : S_E2;
         S_E2:    state_d = (op_len == 3'd2) ? bnd_state : S_E3;
         S_E3:    state_d = (op_len == 3'd3) ? bnd_state : S_E4;
         S_E4: begin
            if (op_cls == C_LD && !mem_ready) state_d = S_E4;
            else if (op_len == 3'd4)          state_d = bnd_state;
            else                              state_d = S_E5;
         end
         S_E5: begin
            if (op_cls == C_ST && !mem_ready) state_d = S_E5;
            else                              state_d = bnd_state;
         end
         default: state_d = S_RST;
      endcase
   end

   // Moore strobe decode from state and opcode (branch E4 also gated by CON_FF).
   always_comb begin
      ctl    = '0;
      OpCode = '0;
      Run    = 1'b0;
      case (state_q)
         S_F0: begin
            Run = 1'b1;
            ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.z_in = 1'b1;
            OpCode = ALU_INC_OP;
         end
         S_F1: begin
            Run = 1'b1;
            ctl.zlow_out = 1'b1; ctl.pc_in = 1'b1;
         end
         S_F2: begin
            Run = 1'b1;
            ctl.rd = 1'b1; ctl.mdr_in = 1'b1;
         end
         S_F3: begin
            Run = 1'b1;
            ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1;
         end
         S_E1: begin
            Run = 1'b1;
            case (op_cls)
               C_LD, C_LDI, C_ST: begin
                  ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1;
               end
               C_ALU, C_ADDI: begin
                  ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1;
               end
               C_BR: begin
                  ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1;
               end
               C_OUT: begin
                  ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.outport_in = 1'b1;
               end
               default: ;
            endcase
         end
         S_E2: begin
            Run = 1'b1;
            case (op_cls)
               C_LD, C_LDI, C_ST, C_ADDI: begin
                  ctl.c_out = 1'b1; ctl.z_in = 1'b1;
                  OpCode = ALU_ADD_OP;
               end
               C_ALU: begin
                  ctl.grc = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1;
                  OpCode = IR_op;
               end
               C_BR: begin
                  ctl.pc_out = 1'b1; ctl.y_in = 1'b1;
               end
               default: ;
            endcase
         end
         S_E3: begin
            Run = 1'b1;
            case (op_cls)
               C_LD, C_ST: begin
                  ctl.zlow_out = 1'b1; ctl.mar_in = 1'b1;
               end
               C_LDI, C_ALU, C_ADDI: begin
                  ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
               end
               C_BR: begin
                  ctl.c_out = 1'b1; ctl.z_in = 1'b1;
                  OpCode = ALU_ADD_OP;
               end
               default: ;
            endcase
         end
         S_E4: begin
            Run = 1'b1;
            case (op_cls)
               C_LD: begin
                  ctl.rd = 1'b1; ctl.mdr_in = 1'b1;
               end
               C_ST: begin
                  ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_in = 1'b1;
               end
               C_BR: begin
                  ctl.zlow_out = CON_FF; ctl.pc_in = CON_FF;
               end
               default: ;
            endcase
         end
         S_E5: begin
            Run = 1'b1;
            case (op_cls)
               C_LD: begin
                  ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
               end
               C_ST: ctl.wr = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign PCout     = ctl.pc_out;
   assign Zlowout   = ctl.zlow_out;
   assign MDRout    = ctl.mdr_out;
   assign Cout      = ctl.c_out;
   assign BAout     = ctl.ba_out;
   assign MARin     = ctl.mar_in;
   assign Zin       = ctl.z_in;
   assign PCin      = ctl.pc_in;
   assign MDRin     = ctl.mdr_in;
   assign IRin      = ctl.ir_in;
   assign Yin       = ctl.y_in;
   assign CONin     = ctl.con_in;
   assign OutportIn = ctl.outport_in;
   assign Gra       = ctl.gra;
   assign Grb       = ctl.grb;
   assign Grc       = ctl.grc;
   assign Rin       = ctl.r_in;
   assign Rout      = ctl.r_out;
   assign Read      = ctl.rd;
   assign Write     = ctl.wr;
   assign Illegal   = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a table-driven instruction model pushes per-cycle expected outputs.
// Latency: expectations are queued as each cycle's stimulus is driven and checked on the following falling edge.
// Backpressure: memory waits and Stop pauses are generated by the stimulus and folded into the expected stream.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       clr, CON_FF, mem_ready, Stop;
   logic [4:0] IR_op;
   logic PCout, Zlowout, MDRout, Cout, BAout;
   logic MARin, Zin, PCin, MDRin, IRin, Yin, CONin, OutportIn;
   logic Gra, Grb, Grc, Rin, Rout, Read, Write;
   logic [4:0] OpCode;
   logic Run, Illegal;

   control_unit dut (
      .clk(clk), .clr(clr), .IR_op(IR_op), .CON_FF(CON_FF), .mem_ready(mem_ready), .Stop(Stop),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .BAout(BAout),
      .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .CONin(CONin), .OutportIn(OutportIn), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
      .Rout(Rout), .Read(Read), .Write(Write), .OpCode(OpCode), .Run(Run), .Illegal(Illegal)
   );

   initial forever #5 clk = ~clk;

   // Strobe bit positions inside the bench's expected word.
   localparam logic [19:0] PCOUT   = 20'h00001;
   localparam logic [19:0] ZLOWOUT = 20'h00002;
   localparam logic [19:0] MDROUT  = 20'h00004;
   localparam logic [19:0] COUT    = 20'h00008;
   localparam logic [19:0] BAOUT   = 20'h00010;
   localparam logic [19:0] MARIN   = 20'h00020;
   localparam logic [19:0] ZIN     = 20'h00040;
   localparam logic [19:0] PCIN    = 20'h00080;
   localparam logic [19:0] MDRIN   = 20'h00100;
   localparam logic [19:0] IRIN    = 20'h00200;
   localparam logic [19:0] YIN     = 20'h00400;
   localparam logic [19:0] CONIN   = 20'h00800;
   localparam logic [19:0] OUTIN   = 20'h01000;
   localparam logic [19:0] GRA     = 20'h02000;
   localparam logic [19:0] GRB     = 20'h04000;
   localparam logic [19:0] GRC     = 20'h08000;
   localparam logic [19:0] RIN     = 20'h10000;
   localparam logic [19:0] ROUT    = 20'h20000;
   localparam logic [19:0] READ    = 20'h40000;
   localparam logic [19:0] WRITE   = 20'h80000;
   localparam logic [4:0]  ADD     = 5'd2;
   localparam logic [4:0]  INC     = 5'd12;

   logic [26:0] got;
   assign got = {Illegal, Run, OpCode, Write, Read, Rout, Rin, Grc, Grb, Gra, OutportIn, CONin,
                 Yin, IRin, MDRin, PCin, Zin, MARin, BAout, Cout, MDRout, Zlowout, PCout};

   logic [26:0] exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  cyc = 0;
   logic model_ill = 1'b0;
   logic halted = 1'b0;
   logic end_req = 1'b0;
   logic end_done = 1'b0;

   function automatic logic [26:0] mk(input logic [19:0] s, input logic [4:0] o);
      return {model_ill, 1'b1, o, s};
   endfunction

   function automatic logic [26:0] idle_exp();
      return {model_ill, 1'b0, 5'd0, 20'd0};
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic op_legal(input logic [4:0] op);
      return (op <= 5'd11) || op == 5'd13 || op == 5'd18 || op == 5'd22 || op == 5'd26 || op == 5'd27;
   endfunction

   // Monitor: one expected word per cycle, compared on the falling edge.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (exp_q.size() != 0) begin
         logic [26:0] e;
         e = exp_q.pop_front();
         n_cmp++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL outputs cycle %0d: got %h required %h", cyc, got, e);
         end
      end else if (end_req && !end_done) begin
         end_done = 1'b1;
         n_cmp++;
         if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_expectations: got %0d required 0", exp_q.size());
         end
      end
   end

   // Drive one cycle of inputs just after the edge and queue that cycle's expected outputs.
   task automatic step(input logic [26:0] e, input logic [4:0] op, input logic con,
                       input logic mr, input logic stp, input logic rs);
      @(posedge clk);
      #1;
      clr = rs; IR_op = op; CON_FF = con; mem_ready = mr; Stop = stp;
      exp_q.push_back(e);
   endtask

   task automatic pause_cycles();
      int n;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) step(idle_exp(), 5'($urandom), rb(), rb(), (i < n - 1), 1'b0);
   endtask

   task automatic do_reset(input logic stp);
      int n;
      n = $urandom_range(1, 3);
      model_ill = 1'b0;
      halted    = 1'b0;
      for (int i = 0; i < n; i++) step(idle_exp(), 5'($urandom), rb(), rb(), rb(), 1'b1);
      step(idle_exp(), 5'($urandom), rb(), rb(), stp, 1'b0);
      if (stp) pause_cycles();
   endtask

   task automatic halt_then_reset();
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) step(idle_exp(), 5'($urandom), rb(), rb(), rb(), 1'b0);
      do_reset(rb());
   endtask

   // One instruction from F0 to its boundary: wf/we = mem_ready-low cycles in fetch / execute wait.
   task automatic do_instr(input logic [4:0] op, input logic con, input int wf, input int we,
                           input logic stp_b);
      logic [19:0] es[$];
      logic [4:0]  eo[$];
      int   mem_i;
      logic halts, ill, last;
      mem_i = -1; halts = 1'b0; ill = 1'b0;
      case (op)
         5'd0, 5'd1, 5'd2: begin
            es.push_back(GRB | BAOUT | YIN);   eo.push_back(5'd0);
            es.push_back(COUT | ZIN);          eo.push_back(ADD);
            if (op == 5'd1) begin
               es.push_back(ZLOWOUT | GRA | RIN); eo.push_back(5'd0);
            end else begin
               es.push_back(ZLOWOUT | MARIN);     eo.push_back(5'd0);
               if (op == 5'd0) begin
                  es.push_back(READ | MDRIN);         eo.push_back(5'd0); mem_i = 3;
                  es.push_back(MDROUT | GRA | RIN);   eo.push_back(5'd0);
               end else begin
                  es.push_back(GRA | ROUT | MDRIN);   eo.push_back(5'd0);
                  es.push_back(WRITE);                eo.push_back(5'd0); mem_i = 4;
               end
            end
         end
         5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
            es.push_back(GRB | ROUT | YIN);    eo.push_back(5'd0);
            es.push_back(GRC | ROUT | ZIN);    eo.push_back(op);
            es.push_back(ZLOWOUT | GRA | RIN); eo.push_back(5'd0);
         end
         5'd13: begin
            es.push_back(GRB | ROUT | YIN);    eo.push_back(5'd0);
            es.push_back(COUT | ZIN);          eo.push_back(ADD);
            es.push_back(ZLOWOUT | GRA | RIN); eo.push_back(5'd0);
         end
         5'd18: begin
            es.push_back(GRA | ROUT | CONIN);  eo.push_back(5'd0);
            es.push_back(PCOUT | YIN);         eo.push_back(5'd0);
            es.push_back(COUT | ZIN);          eo.push_back(ADD);
            es.push_back(con ? (ZLOWOUT | PCIN) : 20'd0); eo.push_back(5'd0);
         end
         5'd22: begin
            es.push_back(GRA | ROUT | OUTIN);  eo.push_back(5'd0);
         end
         5'd26: ;
         5'd27: halts = 1'b1;
         default: begin halts = 1'b1; ill = 1'b1; end
      endcase

      // Fetch: the opcode is irrelevant before F2, so it is scrambled there.
      step(mk(PCOUT | MARIN | ZIN, INC), 5'($urandom), con, rb(), rb(), 1'b0);
      step(mk(ZLOWOUT | PCIN, 5'd0),     5'($urandom), con, rb(), rb(), 1'b0);
      for (int i = 0; i <= wf; i++) step(mk(READ | MDRIN, 5'd0), op, con, (i == wf), rb(), 1'b0);
      last = (es.size() == 0) && !halts;
      step(mk(MDROUT | IRIN, 5'd0), op, con, rb(), last ? stp_b : rb(), 1'b0);
      if (halts) begin
         model_ill = model_ill | ill;
         halted    = 1'b1;
         return;
      end

      for (int k = 0; k < es.size(); k++) begin
         last = (k == es.size() - 1);
         if (k == mem_i) begin
            for (int i = 0; i <= we; i++)
               step(mk(es[k], eo[k]), op, con, (i == we), (last && i == we) ? stp_b : rb(), 1'b0);
         end else begin
            step(mk(es[k], eo[k]), op, con, rb(), last ? stp_b : rb(), 1'b0);
         end
      end
      if (stp_b) pause_cycles();
   endtask

   function automatic logic [4:0] pick_op();
      int r;
      logic [4:0] v;
      r = $urandom_range(0, 99);
      if (r < 12)      v = 5'd0;
      else if (r < 22) v = 5'd1;
      else if (r < 34) v = 5'd2;
      else if (r < 52) v = 5'($urandom_range(3, 11));
      else if (r < 60) v = 5'd13;
      else if (r < 72) v = 5'd18;
      else if (r < 80) v = 5'd22;
      else if (r < 88) v = 5'd26;
      else if (r < 94) v = 5'd27;
      else begin
         v = 5'($urandom);
         while (op_legal(v)) v = 5'($urandom);
      end
      return v;
   endfunction

   initial begin
      clr = 1'b1; IR_op = 5'd0; CON_FF = 1'b0; mem_ready = 1'b0; Stop = 1'b0;

      // Boot out of reset straight into fetch.
      do_reset(1'b0);

      // Reset asserted while fetch waits in F2, then released with Stop low.
      step(mk(PCOUT | MARIN | ZIN, INC), 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(mk(ZLOWOUT | PCIN, 5'd0),     5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(mk(READ | MDRIN, 5'd0),       5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(idle_exp(),                   5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(idle_exp(),                   5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      do_instr(5'd2,  1'b0, 0, 0, 1'b0);   // st, memory ready
      do_instr(5'd0,  1'b0, 0, 3, 1'b0);   // ld, three wait cycles in E4
      do_instr(5'd3,  1'b0, 0, 0, 1'b0);   // R-type add
      do_instr(5'd18, 1'b0, 0, 0, 1'b0);   // branch not taken
      do_instr(5'd18, 1'b1, 0, 0, 1'b0);   // branch taken
      do_instr(5'd1,  1'b0, 0, 0, 1'b1);   // ldi, then pause
      do_instr(5'd22, 1'b0, 2, 0, 1'b0);   // out with slow fetch
      do_instr(5'd26, 1'b0, 0, 0, 1'b1);   // nop, then pause
      do_instr(5'd30, 1'b0, 0, 0, 1'b0);   // undefined opcode
      halt_then_reset();

      for (int n = 0; n < 160; n++) begin
         do_instr(pick_op(), rb(),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                  ($urandom_range(0, 4) == 0));
         if (halted) halt_then_reset();
      end

      @(posedge clk);
      #1;
      end_req = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
